// File: rtl/ibex_branch_resolve_if.sv
// ibex_branch_resolve_if: bundles the prediction push, the resolve and flush inputs,
// and the redirect/status outputs of ibex_branch_resolve.
//   master : fetch/EX/controller side (drives pred_* / res_* / flush_i)
//   slave  : the resolve block itself
// DEPTH must match the DEPTH of the attached ibex_branch_resolve. It sets the occupancy width.
interface ibex_branch_resolve_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pred_valid_i;
  logic          pred_ready_o;
  logic [31:0]   pred_pc_i;
  logic          pred_taken_i;
  logic [31:0]   pred_target_i;
  logic          pred_compressed_i;
  logic          res_valid_i;
  logic          res_taken_i;
  logic [31:0]   res_target_i;
  logic          flush_i;
  logic          redirect_o;
  logic [31:0]   redirect_pc_o;
  logic          res_err_o;
  logic [CW-1:0] occupancy_o;
  logic [31:0]   branch_cnt_o;
  logic [31:0]   mispred_cnt_o;

  modport master (
    output pred_valid_i, pred_pc_i, pred_taken_i, pred_target_i, pred_compressed_i,
    output res_valid_i, res_taken_i, res_target_i, flush_i,
    input  pred_ready_o, redirect_o, redirect_pc_o, res_err_o, occupancy_o,
    input  branch_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  pred_valid_i, pred_pc_i, pred_taken_i, pred_target_i, pred_compressed_i,
    input  res_valid_i, res_taken_i, res_target_i, flush_i,
    output pred_ready_o, redirect_o, redirect_pc_o, res_err_o, occupancy_o,
    output branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/ibex_branch_resolve.sv
// ibex_branch_resolve: in-order queue of fetch-stage predictions. Each record is
// checked against the EX-stage outcome. A mispredict produces a registered
// one-cycle redirect with the corrected PC and drops all younger records.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : ibex_branch_resolve_if.slave carrying the push and resolve inputs, flush,
//           redirect, error, occupancy and the saturating branch/mispredict counters
module ibex_branch_resolve #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  ibex_branch_resolve_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        compressed;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          redirect_q, err_q;
  logic [31:0]   redirect_pc_q, branch_cnt_q, mispred_cnt_q;

  entry_t      head, wr_entry;
  logic        has_head, resolve, mispred, pop, push, res_err;
  logic [31:0] redir_pc;

  assign head     = mem_q[rptr_q];
  assign has_head = (cnt_q != '0);
  // A flush overrides any resolve in the same cycle.
  assign resolve  = bus.res_valid_i & has_head & ~bus.flush_i;
  assign mispred  = resolve & ((head.taken != bus.res_taken_i) |
                               (head.taken & bus.res_taken_i & (head.target != bus.res_target_i)));
  assign pop      = resolve & ~mispred;
  assign res_err  = bus.res_valid_i & ~has_head & ~bus.flush_i;

  // When the queue is full, a correct pop in the same cycle frees a slot for the push.
  assign bus.pred_ready_o = (cnt_q < CW'(DEPTH)) | pop;
  // A push in the same cycle as a flush or mispredict is on the wrong path, so it is dropped.
  assign push = bus.pred_valid_i & bus.pred_ready_o & ~bus.flush_i & ~mispred;

  // Fall-through PC wraps at 2^32 because the carry out is discarded.
  assign redir_pc = bus.res_taken_i ? bus.res_target_i
                                    : head.pc + (head.compressed ? 32'd2 : 32'd4);

  assign wr_entry = '{pc: bus.pred_pc_i, taken: bus.pred_taken_i,
                      target: bus.pred_target_i, compressed: bus.pred_compressed_i};

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_entry;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      err_q         <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      redirect_q <= mispred;
      err_q      <= res_err;
      if (mispred) redirect_pc_q <= redir_pc;
      if (resolve && branch_cnt_q != '1) branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (mispred && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      if (bus.flush_i || mispred) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  assign bus.redirect_o    = redirect_q;
  assign bus.redirect_pc_o = redirect_pc_q;
  assign bus.res_err_o     = err_q;
  assign bus.occupancy_o   = cnt_q;
  assign bus.branch_cnt_o  = branch_cnt_q;
  assign bus.mispred_cnt_o = mispred_cnt_q;
endmodule
